pingpong_multiport_buf: RTL
===========================

Name: pingpong_multiport_buf

Overview:
- Double-buffered (ping-pong) on-chip buffer: one write port fills one bank while RD_PORTS parallel read ports fetch a convolution window from the other bank.
- Sits between the feature-map loader (producer) and the convolution array (consumer).
- Successor to the single-bank multi-read buffer: adds bank handoff handshakes, registered reads with a valid flag, range checking and occupancy status.

Parameters:
- DEPTH, 1024, words per bank.
- WIDTH, 16, data word width in bits.
- ADDR_WIDTH, 32, width of every address field.
- RD_PORTS, 5, number of parallel read ports.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address within the current write bank.
- wr_data  in  WIDTH  write data.
- wr_done  in  1  pulse: producer has finished the write bank; hand it to the consumer.
- wr_ready  out  1  write bank is free and accepts writes and wr_done.
- wr_bank  out  1  index of the bank currently being written.
- rd_en  in  1  read strobe; all ports are sampled together.
- rd_addr_np  in  RD_PORTS*ADDR_WIDTH  packed read addresses; port i occupies bits [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH].
- rd_data_np  out  RD_PORTS*WIDTH  packed registered read data, same packing as rd_addr_np.
- rd_valid  out  1  rd_data_np holds the result of the previous accepted read.
- rd_done  in  1  pulse: consumer releases the read bank.
- rd_ready  out  1  read bank is full and readable.
- rd_bank  out  1  index of the bank currently being read.
- full_cnt  out  2  number of full banks (0 to 2).
- addr_err  out  1  sticky flag: an out-of-range address was seen on an accepted access.

Behaviour:
- State:
  - mem: 2 banks x DEPTH x WIDTH; contents are not reset.
  - bank_full[1:0], wr_bank and rd_bank are registers.
- Reset (async, any time, including mid-fill or mid-read): bank_full=0, wr_bank=0, rd_bank=0, rd_valid=0, rd_data_np=0, addr_err=0. Consequently wr_ready=1, rd_ready=0, full_cnt=0.
- Combinational outputs: wr_ready = !bank_full[wr_bank]; rd_ready = bank_full[rd_bank]; full_cnt = bank_full[0] + bank_full[1].
- Write:
  - Accepted when wr_en && wr_ready && wr_addr < DEPTH; then mem[wr_bank][wr_addr] <= wr_data.
  - wr_en while !wr_ready is ignored, with no flag.
  - wr_en && wr_ready with wr_addr >= DEPTH: no write; addr_err <= 1.
- Write handoff:
  - wr_done && wr_ready: bank_full[wr_bank] <= 1 and wr_bank toggles.
  - A write accepted in the same cycle lands in the old bank.
  - wr_done while !wr_ready is ignored.
- Read:
  - Accepted when rd_en && rd_ready. Latency is 1 cycle: on the next edge every port i loads mem[rd_bank][addr_i] into rd_data_np, and rd_valid <= 1.
  - A port with addr_i >= DEPTH loads 0 and sets addr_err <= 1; the other ports are unaffected.
  - When no read is accepted, rd_valid <= 0 and rd_data_np holds its last value.
  - Back-to-back reads give one result per cycle.
- Read handoff:
  - rd_done && rd_ready: bank_full[rd_bank] <= 0 and rd_bank toggles.
  - A read accepted in the same cycle still uses the old bank.
  - rd_done while !rd_ready is ignored.
- Simultaneous events:
  - wr_done and rd_done in the same cycle both take effect.
  - wr_bank == rd_bank cannot be both writable and readable, so there is no conflict on one bank.
- Read/write overlap on the same bank cannot occur; the handshakes enforce exclusive bank ownership.
- addr_err is cleared only by reset.

Test Plan:
- Reset, then write 0..DEPTH-1 with data=addr+0x100 into bank 0, then pulse wr_done -> wr_bank=1, rd_ready=1, rd_bank=0, full_cnt=1, wr_ready=1.
- Read addresses {0,1,2,3,4} with rd_en for one cycle -> next cycle rd_valid=1, rd_data_np = {0x104,0x103,0x102,0x101,0x100} (port 4 in the MSBs); the following cycle rd_valid=0 and the data holds.
- Fill bank 1 with data=0x200+addr, then pulse wr_done while bank 0 is still full -> full_cnt=2, wr_ready=0; a further wr_en to addr 5 is ignored, and after rd_done bank 1 reads mem[5]=0x205.
- Issue rd_done and wr_done in the same cycle with bank 0 full and bank 1 filling -> bank 0 freed and bank 1 full in one edge, rd_bank=1, wr_bank=0, full_cnt=1.
- Read with port 2 address=DEPTH+3 -> port 2 returns 0, ports 0, 1, 3 and 4 return correct data, addr_err=1 and stays 1 until reset.
- Assert rst_n=0 mid-fill with full_cnt=1 -> immediately full_cnt=0, rd_valid=0, rd_data_np=0, wr_bank=rd_bank=0, addr_err=0.

Source files
------------

// File: rtl/pingpong_multiport_buf.sv
// Double-buffered feature-map store: the loader fills one bank while the
// convolution array reads a RD_PORTS-wide window from the other bank.
module pingpong_multiport_buf #(
  parameter int DEPTH      = 1024,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_PORTS   = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           wr_done,
  output logic                           wr_ready,
  output logic                           wr_bank,
  input  logic                           rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr_np,
  output logic [RD_PORTS*WIDTH-1:0]      rd_data_np,
  output logic                           rd_valid,
  input  logic                           rd_done,
  output logic                           rd_ready,
  output logic                           rd_bank,
  output logic [1:0]                     full_cnt,
  output logic                           addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [WIDTH-1:0] mem [2][DEPTH];

  logic [1:0]                bank_full_q, bank_full_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [RD_PORTS*WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      addr_err_q, addr_err_d;

  logic                      wr_ready_c, rd_ready_c;
  logic                      wr_in_range, wr_acc, rd_acc;
  logic [IDX_W-1:0]          wr_idx;
  logic [ADDR_WIDTH-1:0]     rd_addr [RD_PORTS];
  logic [RD_PORTS-1:0]       rd_oor;

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_addr[i] = rd_addr_np[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    rd_oor = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_oor[i] = (rd_addr[i] >= DEPTH_A);
    end
  end

  // Bank ownership: a bank is writable while empty and readable while full,
  // so the write and read sides can never land on the same bank.
  always_comb begin
    wr_ready_c  = !bank_full_q[wr_bank_q];
    rd_ready_c  = bank_full_q[rd_bank_q];
    wr_in_range = (wr_addr < DEPTH_A);
    wr_idx      = wr_addr[IDX_W-1:0];
    wr_acc      = wr_en && wr_ready_c && wr_in_range;
    rd_acc      = rd_en && rd_ready_c;
  end

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    if (wr_done && wr_ready_c) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = !wr_bank_q;
    end
    if (rd_done && rd_ready_c) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = !rd_bank_q;
    end
  end

  always_comb begin
    addr_err_d = addr_err_q;
    if (wr_en && wr_ready_c && !wr_in_range) begin
      addr_err_d = 1'b1;
    end
    if (rd_acc && (|rd_oor)) begin
      addr_err_d = 1'b1;
    end
  end

  // Read stage: out-of-range ports return zero; data holds when idle.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      for (int i = 0; i < RD_PORTS; i++) begin
        if (rd_oor[i]) begin
          rd_data_d[i*WIDTH +: WIDTH] = '0;
        end else begin
          rd_data_d[i*WIDTH +: WIDTH] = mem[rd_bank_q][rd_addr[i][IDX_W-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_bank_q][wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  always_comb begin
    wr_ready   = wr_ready_c;
    rd_ready   = rd_ready_c;
    wr_bank    = wr_bank_q;
    rd_bank    = rd_bank_q;
    rd_valid   = rd_valid_q;
    rd_data_np = rd_data_q;
    addr_err   = addr_err_q;
    full_cnt   = {1'b0, bank_full_q[0]} + {1'b0, bank_full_q[1]};
  end

endmodule
